// File: rtl/jt12_mux_frame.sv
// Frame mixer: accumulates SLOTS channel samples into 12-bit sums, scales by GAIN_SH and queues them in a 2-deep FIFO.
// Optional macro JT12_MUX_CLAMP_EN saturates the scaled word instead of wrapping it.
module jt12_mux_frame #(
    parameter int GAIN_SH = 4,
    parameter int SLOTS   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [8:0]  mux_left,
    input  logic signed [8:0]  mux_right,
    input  logic               mux_sample,
    input  logic               frame_sync,
    output logic signed [15:0] out_left,
    output logic signed [15:0] out_right,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               ovf,
    output logic               resync,
    input  logic               flag_clr
);

    localparam logic [0:0] SYNC_WAIT = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;
    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

    function automatic logic signed [15:0] shape(input logic signed [11:0] s);
        logic signed [19:0] w;
        w = {{8{s[11]}}, s} <<< GAIN_SH;
`ifdef JT12_MUX_CLAMP_EN
        if (w > 20'sd32767)
            shape = 16'sh7FFF;
        else if (w < -20'sd32768)
            shape = 16'sh8000;
        else
            shape = w[15:0];
`else
        shape = w[15:0];
`endif
    endfunction

    logic [0:0]         state;
    logic [2:0]         slot;
    logic signed [11:0] acc_l_p0, acc_r_p0;
    logic signed [11:0] smp_l, smp_r, sum_l, sum_r;
    logic               resync_set;

    assign smp_l = {{3{mux_left[8]}}, mux_left};
    assign smp_r = {{3{mux_right[8]}}, mux_right};
    assign sum_l = acc_l_p0 + smp_l;
    assign sum_r = acc_r_p0 + smp_r;
    assign resync_set = mux_sample && frame_sync && (state == RUN) && (slot != 3'd0);

    logic               vld_p1;
    logic signed [15:0] word_l_p1, word_r_p1;

    // Stage p0: slot accumulation; stage p1 holds the finished frame word for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC_WAIT;
            slot      <= 3'd0;
            acc_l_p0  <= 12'sd0;
            acc_r_p0  <= 12'sd0;
            vld_p1    <= 1'b0;
            word_l_p1 <= 16'sd0;
            word_r_p1 <= 16'sd0;
        end else begin
            vld_p1 <= 1'b0;
            if (mux_sample) begin
                if (state == SYNC_WAIT) begin
                    if (frame_sync) begin
                        acc_l_p0 <= smp_l;
                        acc_r_p0 <= smp_r;
                        slot     <= 3'd1;
                        state    <= RUN;
                    end
                end else if (resync_set || slot == 3'd0) begin
                    acc_l_p0 <= smp_l;
                    acc_r_p0 <= smp_r;
                    slot     <= 3'd1;
                end else if (slot == LAST_SLOT) begin
                    word_l_p1 <= shape(sum_l);
                    word_r_p1 <= shape(sum_r);
                    vld_p1    <= 1'b1;
                    slot      <= 3'd0;
                end else begin
                    acc_l_p0 <= sum_l;
                    acc_r_p0 <= sum_r;
                    slot     <= slot + 3'd1;
                end
            end
        end
    end

    logic signed [15:0] mem_l [2];
    logic signed [15:0] mem_r [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;
    logic               pop, full, push_ok, ovf_set;

    assign out_valid = (count != 2'd0);
    assign out_left  = mem_l[rd_ptr];
    assign out_right = mem_r[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign full      = (count == 2'd2);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok   = vld_p1 && (!full || pop);
    assign ovf_set   = vld_p1 && full && !pop;

    // Stage p2: output FIFO and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_l[0] <= 16'sd0;
            mem_l[1] <= 16'sd0;
            mem_r[0] <= 16'sd0;
            mem_r[1] <= 16'sd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            ovf      <= 1'b0;
            resync   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_l[wr_ptr] <= word_l_p1;
                mem_r[wr_ptr] <= word_r_p1;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push_ok && !pop)
                count <= count + 2'd1;
            else if (!push_ok && pop)
                count <= count - 2'd1;

            if (ovf_set)
                ovf <= 1'b1;
            else if (flag_clr)
                ovf <= 1'b0;
            if (resync_set)
                resync <= 1'b1;
            else if (flag_clr)
                resync <= 1'b0;
        end
    end

endmodule
